ps2_device_emulator: RTL
========================

Name: ps2_device_emulator

Overview:
- Device-side (keyboard/mouse) end of the PS/2 link. Generates the PS/2 clock, transmits bytes to a host, and receives host-to-device commands (request-to-send, host data, device ACK).
- Used to drive the host PS/2 controller on-board or in loopback and simulation, with no physical keyboard or mouse.

Parameters:
- CLK_HALF, 2000, CLOCK_50 cycles per PS/2 clock half-period (12.5 kHz).
- IDLE_MIN, 2500, cycles both lines must be high before the device starts a frame (50 us).
- INHIBIT_MIN, 5000, cycles the host must hold clock low to count as inhibit/RTS (100 us).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send to the host.
- tx_valid  in  1  tx_data valid; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high when the device can accept a byte.
- rx_data  out  8  host command byte; held until the next reception.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- rx_parity_error  out  1  qualified by rx_valid; 1 = odd-parity check failed.
- tx_abort  out  1  one-cycle pulse, host inhibited a frame in progress.
- busy  out  1  high in any state except IDLE.
- PS2_CLK  inout  1  open-drain: driven 0 or released (z).
- PS2_DAT  inout  1  open-drain: driven 0 or released (z).

Behaviour:
- **Reset values:**
  - Both lines released; tx_ready=1; busy=0.
  - rx_valid=0, rx_parity_error=0, tx_abort=0, rx_data=8'h00.
  - FSM in IDLE; all counters 0.
- **Input sampling:** PS2_CLK/PS2_DAT pass through 2-flop synchronizers. All decisions use the synchronized values.
- **Host clock-low detection:** counted only while the device is releasing PS2_CLK.
- **Bit timing:** each bit is one clock cycle of the generated PS/2 clock, high CLK_HALF cycles then low CLK_HALF cycles.
  - Device changes PS2_DAT at CLK_HALF/2 into the high phase.
  - Device samples host data on the rising clock edge, i.e. the last cycle of the low phase.
- **Idle counter:** counts cycles with both lines high. Saturates at IDLE_MIN; clears whenever either line is low.
- **FSM states:**
  - IDLE:
    - Host clock low for INHIBIT_MIN cycles → INHIBIT.
    - Else, if a byte is pending and the idle counter = IDLE_MIN → TX.
  - TX: sends 11 bits: start 0, data LSB first, odd parity, stop 1.
    - Stop bit is "driven" by releasing PS2_DAT.
    - After the 11th clock's low phase, clock released, byte retired, tx_ready=1 → IDLE.
    - Host holds clock low during any high phase before the 11th rising edge: device releases both lines within 1 cycle, pulses tx_abort, keeps the byte pending → INHIBIT.
  - INHIBIT: waits for host clock release.
    - If PS2_DAT is low at release (RTS) → RX.
    - Else → IDLE.
  - RX: device generates 10 clocks and samples 8 data bits, parity, stop.
    - Stop sampled 0: keep clocking until PS2_DAT=1 is sampled, maximum 8 extra clocks, then proceed.
  - ACK: device drives PS2_DAT low for the 11th clock, then releases both lines.
    - rx_valid pulses for one cycle at ACK completion, with rx_parity_error = (XOR of data and parity bits) == 0.
    - → IDLE.
- **tx_ready:**
  - Falls the cycle after acceptance.
  - Stays low through any abort/retry until the byte completes a full frame.
  - One-byte pending register only.
- **Priority:** host RTS always preempts a pending TX. A pending TX retries from IDLE only after IDLE_MIN idle cycles.
- **Mid-operation reset:** lines released asynchronously; pending byte discarded; no pulses emitted.
- **Parity computation:** parity bit = ~^data.

Optional Feature:
- Macro: PS2_DEVICE_AUTO_ACK_EN.
- **Defined:** after each rx_valid, the device automatically queues a response byte ahead of any user byte.
  - 8'hFA if parity was good, 8'hFE if bad.
  - tx_ready is held low until that response frame completes.
  - A user byte already pending is sent after the response.
- **Undefined:** no automatic response; only user-supplied bytes are transmitted.

Test Plan:
1. tx_data=8'h1C with tx_valid, bus idle → frame bits 0,0,0,1,1,1,0,0,0,0,1 (start, 1C LSB first, parity 0, stop) at 12.5 kHz; tx_ready high only after the 11th clock.
2. Host model: clock low 120 us, data low, release clock, shift 8'hF4 with parity 0 → device ACK low on the 11th clock; rx_valid pulse with rx_data=F4, rx_parity_error=0.
3. Same RTS as test 2 but parity bit flipped → rx_valid with rx_parity_error=1. With the macro: device then transmits 8'hFE; without it: the bus stays idle.
4. Device sending 8'hAA; host holds clock low during the 5th clock's high phase → lines released within 1 cycle, one tx_abort pulse; after host release plus IDLE_MIN, full AA frame resent; tx_ready rises once.
5. Assert reset mid-RX at bit 4 → both lines immediately z; rx_valid never pulses; tx_ready=1.
6. Macro defined, user byte 8'h55 pending during a good host command 8'hFF → transmit order FA then 55.

Source files
------------

// File: rtl/ps2_device_emulator.sv
`timescale 1ns/1ps
// ps2_device_emulator: device-side (keyboard/mouse) end of a PS/2 link.
// Generates the PS/2 clock, sends bytes to the host and receives host
// commands (request-to-send, data, ACK). Both lines are open-drain.
// Optional feature macro: PS2_DEVICE_AUTO_ACK_EN -- after every received
// command the device queues FA (good parity) or FE (bad parity) ahead of
// any user byte.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | lines released, watching for host inhibit or a byte to send
// S_TX      | clocking out start, 8 data bits, odd parity, stop
// S_INHIBIT | host holds clock low; wait for release, data low means RTS
// S_RX      | clocking in 8 data bits, parity, stop (up to 8 extra clocks)
// S_ACK     | 11th clock with data driven low, then back to idle
module ps2_device_emulator #(
    parameter int CLK_HALF    = 2000,
    parameter int IDLE_MIN    = 2500,
    parameter int INHIBIT_MIN = 5000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_error,
    output logic       tx_abort,
    output logic       busy,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);
    localparam int TW = $clog2(CLK_HALF);
    localparam int IW = $clog2(IDLE_MIN + 1);
    localparam int HW = $clog2(INHIBIT_MIN + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(CLK_HALF - 1);
    localparam logic [TW-1:0] TMR_CHG  = TW'(CLK_HALF - 1 - CLK_HALF / 2);
    // our own clock release takes two synchronizer cycles to show up, so a
    // host hold is only believed from the third cycle of a high phase on
    localparam logic [TW-1:0] TMR_HOLD = TW'(CLK_HALF - 3);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_INHIBIT, S_RX, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          phase_q, phase_d;          // 0 = clock high, 1 = clock low
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    extra_q, extra_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic [10:0]   tx_frame_q, tx_frame_d;
    logic [8:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_perr_q, rx_perr_d;
    logic          tx_abort_q, tx_abort_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          ack_pend_q, ack_pend_d;
    logic [7:0]    ack_data_q, ack_data_d;
    logic          sel_ack_q, sel_ack_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [HW-1:0] inh_cnt_q, inh_cnt_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;

    logic       clk_s, dat_s, half_end, rise, dat_chg, host_hold;
    logic [7:0] next_byte;

    assign clk_s     = clk_sync_q[1];
    assign dat_s     = dat_sync_q[1];
    assign half_end  = (tmr_q == '0);
    assign rise      = half_end && phase_q;
    assign dat_chg   = !phase_q && (tmr_q == TMR_CHG);
    assign host_hold = !phase_q && (tmr_q <= TMR_HOLD) && !clk_s;
    assign next_byte = ack_pend_q ? ack_data_q : pend_data_q;

    assign PS2_CLK         = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT         = dat_oe_q ? 1'b0 : 1'bz;
    assign tx_ready        = !pend_q && !ack_pend_q;
    assign busy            = (state_q != S_IDLE);
    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign rx_parity_error = rx_perr_q;
    assign tx_abort        = tx_abort_q;

    // state and datapath registers; reset releases both lines at once
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            phase_q     <= 1'b0;
            bit_cnt_q   <= '0;
            extra_q     <= '0;
            clk_oe_q    <= 1'b0;
            dat_oe_q    <= 1'b0;
            tx_frame_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_perr_q   <= 1'b0;
            tx_abort_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            ack_pend_q  <= 1'b0;
            ack_data_q  <= '0;
            sel_ack_q   <= 1'b0;
            idle_cnt_q  <= '0;
            inh_cnt_q   <= '0;
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            extra_q     <= extra_d;
            clk_oe_q    <= clk_oe_d;
            dat_oe_q    <= dat_oe_d;
            tx_frame_q  <= tx_frame_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_perr_q   <= rx_perr_d;
            tx_abort_q  <= tx_abort_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            ack_pend_q  <= ack_pend_d;
            ack_data_q  <= ack_data_d;
            sel_ack_q   <= sel_ack_d;
            idle_cnt_q  <= idle_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
        end
    end

    // next-state, bit timing, line drive and byte bookkeeping
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        extra_d     = extra_q;
        dat_oe_d    = dat_oe_q;
        tx_frame_d  = tx_frame_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_perr_d   = rx_perr_q;
        tx_abort_d  = 1'b0;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ack_pend_d  = ack_pend_q;
        ack_data_d  = ack_data_q;
        sel_ack_d   = sel_ack_q;
        inh_cnt_d   = '0;
        clk_sync_d  = {clk_sync_q[0], PS2_CLK};
        dat_sync_d  = {dat_sync_q[0], PS2_DAT};

        if (clk_s && dat_s)
            idle_cnt_d = (idle_cnt_q == IW'(IDLE_MIN)) ? idle_cnt_q : idle_cnt_q + IW'(1);
        else
            idle_cnt_d = '0;

        if (tx_valid && tx_ready) begin
            pend_d      = 1'b1;
            pend_data_d = tx_data;
        end

        if (state_q inside {S_TX, S_RX, S_ACK}) begin
            if (half_end) begin
                tmr_d   = TMR_LOAD;
                phase_d = !phase_q;
            end else begin
                tmr_d = tmr_q - TW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!clk_oe_q && !clk_s)
                    inh_cnt_d = (inh_cnt_q == HW'(INHIBIT_MIN)) ? inh_cnt_q : inh_cnt_q + HW'(1);
                if (inh_cnt_q == HW'(INHIBIT_MIN)) begin
                    state_d = S_INHIBIT;
                end else if ((pend_q || ack_pend_q) && idle_cnt_q == IW'(IDLE_MIN)) begin
                    state_d    = S_TX;
                    tmr_d      = TMR_LOAD;
                    phase_d    = 1'b0;
                    bit_cnt_d  = '0;
                    sel_ack_d  = ack_pend_q;
                    tx_frame_d = {1'b1, ~^next_byte, next_byte, 1'b0};
                end
            end
            S_TX: begin
                if (host_hold) begin
                    state_d    = S_INHIBIT;
                    dat_oe_d   = 1'b0;
                    tx_abort_d = 1'b1;
                end else if (dat_chg) begin
                    dat_oe_d = !tx_frame_q[0];
                end else if (rise) begin
                    if (bit_cnt_q == 4'd10) begin
                        state_d  = S_IDLE;
                        dat_oe_d = 1'b0;
                        if (sel_ack_q) ack_pend_d = 1'b0;
                        else           pend_d     = 1'b0;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        tx_frame_d = {1'b0, tx_frame_q[10:1]};
                    end
                end
            end
            S_INHIBIT: begin
                if (clk_s) begin
                    if (!dat_s) begin
                        state_d   = S_RX;
                        tmr_d     = TMR_LOAD;
                        phase_d   = 1'b0;
                        bit_cnt_d = '0;
                        extra_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RX: begin
                if (rise) begin
                    if (bit_cnt_q < 4'd9) begin
                        rx_shift_d = {dat_s, rx_shift_q[8:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end else if (dat_s || extra_q == 4'd8) begin
                        state_d = S_ACK;
                    end else begin
                        extra_d = extra_q + 4'd1;
                    end
                end
            end
            S_ACK: begin
                if (dat_chg) dat_oe_d = 1'b1;
                if (rise) begin
                    state_d    = S_IDLE;
                    dat_oe_d   = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q[7:0];
                    rx_perr_d  = ~^rx_shift_q;
`ifdef PS2_DEVICE_AUTO_ACK_EN
                    ack_pend_d = 1'b1;
                    ack_data_d = (^rx_shift_q) ? 8'hFA : 8'hFE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        clk_oe_d = (state_d inside {S_TX, S_RX, S_ACK}) && phase_d;
    end
endmodule
